alu_exec_stage: RTL and testbench

// Execute stage of the 16-bit single-cycle CPU: operand-B mux + ALU-control decode + ALU, with registered outputs.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 34 +++
 rtl/alu_exec_stage.sv | 50 +++++
 tb/tb_alu_exec_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, ALU operation codes and opcodes for the execute stage
package alu_pkg;
  localparam int WIDTH = 16;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;
  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_ANDI  = 3'd6;
  localparam logic [2:0] OP_ORI   = 3'd7;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, carry/borrow and zero flag
module alu_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_code,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH-5:0] unused_b;
  assign sum = {1'b0, a} + {1'b0, b};
  // bit WIDTH of the widened difference is the unsigned borrow
  assign diff = {1'b0, a} - {1'b0, b};
  assign unused_b = b[WIDTH-1:4];
  always_comb begin
    result = '0;
    carry = 1'b0;
    case (alu_code)
      ALU_ADD: {carry, result} = sum;
      ALU_SUB: {carry, result} = diff;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      default: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
    endcase
  end
  assign zero = (result == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: operand-B select, ALU-control decode, ALU and registered flags
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [3:0]       func,
  input  logic [6:0]       immediate,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read2,
  input  logic             aluop,
  output logic [2:0]       alu_code,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             is_zero
);
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             result_carry;
  logic             result_zero;
  logic             unused_func;
  assign unused_func = func[3];
  assign operand_b = aluop ? {{(WIDTH-7){immediate[6]}}, immediate} : read2;
  always_comb begin
    alu_code = opcode == OP_RTYPE ? func[2:0] :
               opcode == OP_BEQ   ? ALU_SUB :
               opcode == OP_ANDI  ? ALU_AND :
               opcode == OP_ORI   ? ALU_OR  : ALU_ADD;
  end
  alu_core u_core (
    .a(read1),
    .b(operand_b),
    .alu_code(alu_code),
    .result(result),
    .carry(result_carry),
    .zero(result_zero)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out <= '0;
      carry <= 1'b0;
      is_zero <= 1'b1;
    end else begin
      alu_out <= result;
      carry <= result_carry;
      is_zero <= result_zero;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table, random model vectors and reset sequences
module tb_alu_exec_stage;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  func;
  logic [6:0]  immediate;
  logic [15:0] read1;
  logic [15:0] read2;
  logic        aluop;
  logic [2:0]  alu_code;
  logic [15:0] alu_out;
  logic        carry;
  logic        is_zero;
  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [6:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic [2:0]  code;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;
  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
  } exp_t;
  vec_t vecs[20];
  vec_t v;
  exp_t e;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  alu_exec_stage dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .immediate(immediate),
    .read1(read1), .read2(read2), .aluop(aluop), .alu_code(alu_code),
    .alu_out(alu_out), .carry(carry), .is_zero(is_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    opcode = x.op;
    func = x.fn;
    immediate = x.imm;
    read1 = x.a;
    read2 = x.b;
    aluop = x.sel;
  endtask
  task automatic check_out(input string tag);
    exp_t x;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      x = q.pop_front();
      chk({tag, "_alu_out"}, {16'h0, alu_out}, {16'h0, x.res});
      chk({tag, "_carry"}, {31'h0, carry}, {31'h0, x.c});
      chk({tag, "_is_zero"}, {31'h0, is_zero}, {31'h0, x.z});
    end
  endtask
  function automatic logic [2:0] dec(input logic [2:0] op, input logic [3:0] fn);
    case (op)
      3'd0: dec = fn[2:0];
      3'd4: dec = 3'd1;
      3'd6: dec = 3'd2;
      3'd7: dec = 3'd3;
      default: dec = 3'd0;
    endcase
  endfunction
  function automatic exp_t model(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b);
    exp_t m;
    int sa, sb;
    m.c = 1'b0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (code)
      3'd0: begin m.res = 16'(32'(a) + 32'(b)); m.c = (32'(a) + 32'(b)) > 32'hFFFF; end
      3'd1: begin m.res = 16'(32'(a) - 32'(b)); m.c = a < b; end
      3'd2: m.res = a & b;
      3'd3: m.res = a | b;
      3'd4: m.res = a ^ b;
      3'd5: m.res = 16'(32'(a) * (32'd1 << b[3:0]));
      3'd6: m.res = 16'(32'(a) / (32'd1 << b[3:0]));
      default: m.res = (sa < sb) ? 16'd1 : 16'd0;
    endcase
    m.z = (m.res == 16'h0);
    return m;
  endfunction
  initial begin
    vecs[0]  = '{3'd0, 4'h0, 7'h00, 16'hFFFF, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{3'd4, 4'h0, 7'h00, 16'h0005, 16'h0007, 1'b0, 3'd1, 16'hFFFE, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 4'h0, 7'h7F, 16'h0002, 16'h0000, 1'b1, 3'd0, 16'h0001, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 4'h0, 7'h3F, 16'h0002, 16'h0000, 1'b1, 3'd0, 16'h0041, 1'b0, 1'b0};
    vecs[4]  = '{3'd0, 4'h5, 7'h00, 16'h0001, 16'h00FF, 1'b0, 3'd5, 16'h8000, 1'b0, 1'b0};
    vecs[5]  = '{3'd0, 4'h6, 7'h00, 16'h8000, 16'h0004, 1'b0, 3'd6, 16'h0800, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 4'h7, 7'h00, 16'hFFFF, 16'h0001, 1'b0, 3'd7, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{3'd7, 4'h0, 7'h40, 16'h0003, 16'h0000, 1'b1, 3'd3, 16'hFFC3, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 4'h2, 7'h00, 16'hF0F0, 16'h0F0F, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{3'd0, 4'hC, 7'h00, 16'hAAAA, 16'hFFFF, 1'b0, 3'd4, 16'h5555, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 4'h1, 7'h00, 16'h1234, 16'h1234, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{3'd2, 4'h0, 7'h05, 16'h0010, 16'h0000, 1'b1, 3'd0, 16'h0015, 1'b0, 1'b0};
    vecs[12] = '{3'd3, 4'h0, 7'h40, 16'h0040, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{3'd5, 4'h0, 7'h00, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0003, 1'b0, 1'b0};
    vecs[14] = '{3'd6, 4'h0, 7'h0F, 16'h00FF, 16'h0000, 1'b1, 3'd2, 16'h000F, 1'b0, 1'b0};
    vecs[15] = '{3'd0, 4'h7, 7'h00, 16'h0001, 16'hFFFF, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b1};
    vecs[16] = '{3'd0, 4'h6, 7'h00, 16'h8001, 16'hFFF0, 1'b0, 3'd6, 16'h8001, 1'b0, 1'b0};
    vecs[17] = '{3'd0, 4'h3, 7'h00, 16'h0F00, 16'h00F0, 1'b0, 3'd3, 16'h0FF0, 1'b0, 1'b0};
    vecs[18] = '{3'd0, 4'h0, 7'h7F, 16'h0005, 16'h0000, 1'b1, 3'd0, 16'h0004, 1'b1, 1'b0};
    vecs[19] = '{3'd0, 4'h8, 7'h00, 16'h1000, 16'h2345, 1'b0, 3'd0, 16'h3345, 1'b0, 1'b0};
    rst = 1'b1;
    drive(vecs[19]);
    #2;
    chk("reset_alu_out", {16'h0, alu_out}, 32'h0);
    chk("reset_carry", {31'h0, carry}, 32'h0);
    chk("reset_is_zero", {31'h0, is_zero}, 32'h1);
    @(negedge clk);
    chk("reset_held_alu_out", {16'h0, alu_out}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) check_out($sformatf("vec%0d", i - 1));
      drive(vecs[i]);
      q.push_back('{vecs[i].res, vecs[i].c, vecs[i].z});
      #1 chk($sformatf("vec%0d_alu_code", i), {29'h0, alu_code}, {29'h0, vecs[i].code});
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_out(i == 0 ? "vec19" : $sformatf("rnd%0d", i - 1));
      v.op = 3'($urandom_range(0, 7));
      v.fn = 4'($urandom_range(0, 15));
      v.imm = 7'($urandom_range(0, 127));
      v.a = 16'($urandom_range(0, 65535));
      v.b = 16'($urandom_range(0, 65535));
      v.sel = 1'($urandom_range(0, 1));
      v.code = dec(v.op, v.fn);
      e = model(v.code, v.a, v.sel ? {{9{v.imm[6]}}, v.imm} : v.b);
      drive(v);
      q.push_back(e);
    end
    @(negedge clk);
    check_out("rnd39");
    drive(vecs[13]);
    @(negedge clk);
    chk("pre_reset_alu_out", {16'h0, alu_out}, 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_alu_out", {16'h0, alu_out}, 32'h0);
    chk("async_reset_carry", {31'h0, carry}, 32'h0);
    chk("async_reset_is_zero", {31'h0, is_zero}, 32'h1);
    @(negedge clk);
    chk("reset_over_edge_alu_out", {16'h0, alu_out}, 32'h0);
    drive(vecs[19]);
    #2 rst = 1'b0;
    #1 chk("deassert_no_capture", {16'h0, alu_out}, 32'h0);
    @(negedge clk);
    chk("first_capture_alu_out", {16'h0, alu_out}, 32'h3345);
    chk("first_capture_is_zero", {31'h0, is_zero}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
